// File: rtl/serial_parallel_sync_ctrl_if.sv
// Byte-stream bundle between the deserializer and the symbol-lock controller.
// The master drives the deserializer side; the slave is the lock controller.
interface serial_parallel_sync_ctrl_if;
    logic [7:0] sym_in;
    logic       sym_strobe;
    logic       slip;
    logic       active;
    logic       valid_out;
    logic [7:0] data_out;
    logic [2:0] com_count;
    logic       loss;

    modport master (
        output sym_in,
        output sym_strobe,
        input  slip,
        input  active,
        input  valid_out,
        input  data_out,
        input  com_count,
        input  loss
    );

    modport slave (
        input  sym_in,
        input  sym_strobe,
        output slip,
        output active,
        output valid_out,
        output data_out,
        output com_count,
        output loss
    );
endinterface

// File: rtl/serial_parallel_sync_ctrl.sv
// Symbol-lock controller: hunts for the comma symbol, commands bit-slips while
// unaligned, and forwards payload bytes once the lane has locked.
module serial_parallel_sync_ctrl #(
    parameter logic [7:0] COM_SYMBOL   = 8'hBC,
    parameter int         LOCK_COUNT   = 4,
    parameter int         SLIP_TIMEOUT = 8,
    parameter int         LOSS_TIMEOUT = 16
) (
    input  logic                          clk_4f,
    input  logic                          reset,
    serial_parallel_sync_ctrl_if.slave    sp
);

    localparam logic [7:0] SLIP_LAST   = 8'(SLIP_TIMEOUT - 1);
    localparam logic [7:0] LOSS_LIMIT  = 8'(LOSS_TIMEOUT);
    localparam logic [2:0] LOCK_TARGET = 3'(LOCK_COUNT);
    localparam logic [2:0] COUNT_MAX   = 3'd7;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } state_t;

    state_t     state_reg,     state_next;
    logic [7:0] timer_reg,     timer_next;
    logic [2:0] com_count_reg, com_count_next;
    logic [7:0] data_reg,      data_next;
    logic       slip_reg,      slip_next;
    logic       loss_reg,      loss_next;
    logic       valid_reg,     valid_next;
    logic       active_reg,    active_next;

    logic       is_com;
    logic [2:0] count_inc;
    logic [7:0] timer_inc;

    assign is_com    = (sp.sym_in == COM_SYMBOL);
    assign count_inc = com_count_reg + 3'd1;
    assign timer_inc = timer_reg + 8'd1;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_reg     <= SEARCH;
            timer_reg     <= 8'd0;
            com_count_reg <= 3'd0;
            data_reg      <= 8'h00;
            slip_reg      <= 1'b0;
            loss_reg      <= 1'b0;
            valid_reg     <= 1'b0;
            active_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            com_count_reg <= com_count_next;
            data_reg      <= data_next;
            slip_reg      <= slip_next;
            loss_reg      <= loss_next;
            valid_reg     <= valid_next;
            active_reg    <= active_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        com_count_next = com_count_reg;
        data_next      = data_reg;
        slip_next      = 1'b0;
        loss_next      = 1'b0;
        valid_next     = 1'b0;
        active_next    = active_reg;

        // Pulses default low, so a cycle without a strobe only clears them.
        if (sp.sym_strobe) begin
            unique case (state_reg)
                SEARCH: begin
                    if (is_com) begin
                        com_count_next = 3'd1;
                        timer_next     = 8'd0;
                        if (LOCK_TARGET == 3'd1) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                        end else begin
                            state_next  = LOCKING;
                        end
                    end else if (timer_reg == SLIP_LAST) begin
                        slip_next  = 1'b1;
                        timer_next = 8'd0;
                    end else begin
                        timer_next = timer_inc;
                    end
                end

                LOCKING: begin
                    if (is_com) begin
                        com_count_next = count_inc;
                        if (count_inc == LOCK_TARGET) begin
                            state_next  = ACTIVE;
                            active_next = 1'b1;
                            timer_next  = 8'd0;
                        end
                    end else begin
                        // A broken comma run restarts the hunt without slipping.
                        state_next     = SEARCH;
                        com_count_next = 3'd0;
                        timer_next     = 8'd0;
                    end
                end

                ACTIVE: begin
                    if (is_com) begin
                        timer_next = 8'd0;
                        if (com_count_reg != COUNT_MAX) begin
                            com_count_next = count_inc;
                        end
                    end else begin
                        data_next      = sp.sym_in;
                        valid_next     = 1'b1;
                        com_count_next = 3'd0;
                        if (timer_inc == LOSS_LIMIT) begin
                            // The byte that trips the loss is still forwarded.
                            state_next  = SEARCH;
                            active_next = 1'b0;
                            loss_next   = 1'b1;
                            timer_next  = 8'd0;
                        end else begin
                            timer_next  = timer_inc;
                        end
                    end
                end

                default: begin
                    state_next     = SEARCH;
                    active_next    = 1'b0;
                    timer_next     = 8'd0;
                    com_count_next = 3'd0;
                end
            endcase
        end
    end

    assign sp.slip      = slip_reg;
    assign sp.loss      = loss_reg;
    assign sp.valid_out = valid_reg;
    assign sp.active    = active_reg;
    assign sp.data_out  = data_reg;
    assign sp.com_count = com_count_reg;

endmodule

// File: tb/tb_serial_parallel_sync_ctrl.sv
// Bench for the symbol-lock controller: directed scenarios plus random byte
// streams, all compared cycle by cycle against a counting reference model.
module tb_serial_parallel_sync_ctrl;

    localparam logic [7:0] COM = 8'hBC;
    localparam int LOCK_COUNT   = 4;
    localparam int SLIP_TIMEOUT = 8;
    localparam int LOSS_TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    serial_parallel_sync_ctrl_if sp_if();

    serial_parallel_sync_ctrl #(
        .COM_SYMBOL   (COM),
        .LOCK_COUNT   (LOCK_COUNT),
        .SLIP_TIMEOUT (SLIP_TIMEOUT),
        .LOSS_TIMEOUT (LOSS_TIMEOUT)
    ) dut (
        .clk_4f (clk),
        .reset  (reset),
        .sp     (sp_if)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;
    int slip_seen = 0;
    int loss_seen = 0;

    // Reference model: lock status, length of the current comma run and the
    // number of non-comma strobes since the last comma / slip / loss.
    bit         m_locked;
    int         m_run;
    int         m_gap;
    bit         e_slip, e_loss, e_valid;
    logic [7:0] e_data;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s txn=%0d got=%0h expected=%0h", tag, txn, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_gap = 0;
        e_slip = 0; e_loss = 0; e_valid = 0; e_data = 8'h00;
    endtask

    task automatic model_step(input bit s, input logic [7:0] d);
        e_slip = 0; e_loss = 0; e_valid = 0;
        if (s) begin
            if (d == COM) begin
                m_gap = 0;
                if (m_locked) begin
                    m_run = (m_run < 7) ? m_run + 1 : 7;
                end else begin
                    m_run = m_run + 1;
                    if (m_run == LOCK_COUNT) m_locked = 1;
                end
            end else if (m_locked) begin
                e_valid = 1; e_data = d; m_run = 0;
                m_gap = m_gap + 1;
                if (m_gap == LOSS_TIMEOUT) begin
                    m_locked = 0; e_loss = 1; m_gap = 0;
                end
            end else if (m_run > 0) begin
                m_run = 0; m_gap = 0;
            end else begin
                m_gap = m_gap + 1;
                if (m_gap == SLIP_TIMEOUT) begin
                    e_slip = 1; m_gap = 0;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model, compare every output.
    task automatic cycle(input bit r, input bit s, input logic [7:0] d);
        reset = r;
        sp_if.sym_strobe = s;
        sp_if.sym_in = d;
        @(posedge clk);
        #1;
        txn++;
        if (r) model_reset();
        else   model_step(s, d);
        check_val("slip",      int'(sp_if.slip),      int'(e_slip));
        check_val("loss",      int'(sp_if.loss),      int'(e_loss));
        check_val("valid_out", int'(sp_if.valid_out), int'(e_valid));
        check_val("active",    int'(sp_if.active),    int'(m_locked));
        check_val("com_count", int'(sp_if.com_count), m_run);
        check_val("data_out",  int'(sp_if.data_out),  int'(e_data));
        if (sp_if.slip) slip_seen++;
        if (sp_if.loss) loss_seen++;
        $display("txn %0d rst=%0b stb=%0b sym=%02h -> slip=%0b act=%0b vld=%0b data=%02h cnt=%0d loss=%0b",
                 txn, r, s, d, sp_if.slip, sp_if.active, sp_if.valid_out,
                 sp_if.data_out, sp_if.com_count, sp_if.loss);
    endtask

    task automatic strobe(input logic [7:0] d);
        cycle(1'b0, 1'b1, d);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK_COUNT; i++) strobe(COM);
    endtask

    logic [7:0] rnd;
    int kind, len;

    initial begin
        reset = 1'b1;
        sp_if.sym_strobe = 1'b0;
        sp_if.sym_in = 8'h00;
        model_reset();

        // Lock-up from reset
        do_reset(3);
        lock_up();
        check_val("locked_after_4", int'(sp_if.active), 1);

        // Payload forwarding with an embedded comma
        strobe(8'hBB); strobe(8'hCC); strobe(8'hDD); strobe(8'hEE);
        strobe(COM);   strobe(8'hFF);

        // Slip pulses in SEARCH
        do_reset(1);
        slip_seen = 0;
        for (int i = 0; i < 8; i++) strobe(8'hAA);
        check_val("slip_count_8", slip_seen, 1);
        for (int i = 0; i < 8; i++) strobe(8'hAA);
        check_val("slip_count_16", slip_seen, 2);

        // Broken comma run restarts the hunt
        do_reset(1);
        strobe(COM); strobe(COM); strobe(8'hAA);
        lock_up();

        // Loss timeout and a comma that rescues the timer
        do_reset(1);
        lock_up();
        loss_seen = 0;
        for (int i = 0; i < 16; i++) strobe(8'h00);
        check_val("loss_count_16", loss_seen, 1);
        check_val("search_after_loss", int'(sp_if.active), 0);
        lock_up();
        loss_seen = 0;
        for (int i = 0; i < 15; i++) strobe(8'h00);
        strobe(COM);
        for (int i = 0; i < 15; i++) strobe(8'h00);
        check_val("no_loss_after_com", loss_seen, 0);

        // Reset mid-lock and while active with a strobe present
        do_reset(1);
        strobe(COM); strobe(COM); strobe(COM);
        cycle(1'b1, 1'b1, COM);
        lock_up();
        strobe(8'h5A);
        cycle(1'b1, 1'b1, 8'h77);
        for (int i = 0; i < LOCK_COUNT; i++) begin
            cycle(1'b0, 1'b0, 8'h11);
            cycle(1'b0, 1'b0, COM);
            strobe(COM);
        end

        // Random streams
        for (int b = 0; b < 80; b++) begin
            kind = int'($urandom_range(0, 4));
            len  = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) begin
                rnd = 8'($urandom);
                if (kind == 0 || (kind == 3 && $urandom_range(0, 9) < 4)) rnd = COM;
                else if (rnd == COM) rnd = 8'h3C;
                if (kind == 4 && i == 0 && $urandom_range(0, 5) == 0)
                    cycle(1'b1, 1'($urandom), rnd);
                else if ($urandom_range(0, 3) == 0)
                    cycle(1'b0, 1'b0, rnd);
                else
                    strobe(rnd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
